serial_pattern_tx: RTL and testbench

Serial frame transmitter that drives a single-bit line consumed by the team's serial pattern detector FSMs. A parallel word is accepted on a start/ready handshake and shifted out one bit per clock: a fixed preamble pattern, then the payload MSB-first, then one idle gap cycle. It is the transmit-side counterpart to the `in`-driven detector and is the stimulus source for detector-level system benches.

---
 rtl/serial_pattern_tx.sv | 180 ++++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx
// Serial frame transmitter feeding the serial pattern detector FSMs.
// A parallel word is accepted on a start/ready handshake and shifted out one
// bit per clock: fixed preamble (MSB first), payload (MSB first), optional
// even-parity bit, then one idle gap cycle with a done pulse.
//
// Optional feature macro: SERIAL_PATTERN_TX_PARITY_EN
//   defined     -> PAR state present, even-parity bit appended after payload
//   not defined -> DATA goes straight to GAP
//
// Parameters:
//   DATA_W   payload width in bits (>=1)
//   PRE_W    preamble width in bits (>=1)
//   PREAMBLE preamble pattern, sent MSB first
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset
//   start  in   send request, accepted only while ready=1
//   data   in   payload, sampled on the accepting edge only
//   ready  out  idle and able to accept start
//   busy   out  frame in progress
//   out    out  registered serial line, idle level 0
//   done   out  one-cycle pulse during the gap cycle
// -----------------------------------------------------------------------------
module serial_pattern_tx #(
  parameter int                DATA_W   = 8,
  parameter int                PRE_W    = 3,
  parameter logic [PRE_W-1:0]  PREAMBLE = 3'b101
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              busy,
  output logic              out,
  output logic              done
);

  localparam int MAX_W = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W) + 1;

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_PAR,
    S_GAP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_GAP
  } state_t;
`endif

  state_t              r_state, w_state;
  logic [CNT_W-1:0]    r_cnt,   w_cnt;
  logic [PRE_W-1:0]    r_pre,   w_pre;
  logic [DATA_W-1:0]   r_shift, w_shift;
  logic                r_out,   w_out;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic                r_par,   w_par;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pre   <= '0;
      r_shift <= '0;
      r_out   <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_pre   <= w_pre;
      r_shift <= w_shift;
      r_out   <= w_out;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      r_par   <= w_par;
`endif
    end
  end

  // The line is registered, so each edge loads the bit for the coming cycle:
  // the accepting edge already loads preamble MSB, and the remaining preamble
  // bits come from a pre-shifted copy so no variable index is needed.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_pre   = r_pre;
    w_shift = r_shift;
    w_out   = 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    w_par   = r_par;
`endif

    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (start) begin
          w_state = S_PRE;
          w_shift = data;
          w_pre   = PREAMBLE << 1;
          w_out   = PREAMBLE[PRE_W-1];
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          w_par   = ^data;
`endif
        end
      end

      S_PRE: begin
        if (r_cnt == PRE_LAST) begin
          w_state = S_DATA;
          w_cnt   = '0;
          w_out   = r_shift[DATA_W-1];
          w_shift = r_shift << 1;
        end else begin
          w_cnt   = r_cnt + 1'b1;
          w_out   = r_pre[PRE_W-1];
          w_pre   = r_pre << 1;
        end
      end

      S_DATA: begin
        if (r_cnt == DATA_LAST) begin
          w_cnt   = '0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          w_state = S_PAR;
          w_out   = r_par;
`else
          w_state = S_GAP;
          w_out   = 1'b0;
`endif
        end else begin
          w_cnt   = r_cnt + 1'b1;
          w_out   = r_shift[DATA_W-1];
          w_shift = r_shift << 1;
        end
      end

`ifdef SERIAL_PATTERN_TX_PARITY_EN
      S_PAR: begin
        w_state = S_GAP;
        w_cnt   = '0;
        w_out   = 1'b0;
      end
`endif

      S_GAP: begin
        w_state = S_IDLE;
        w_cnt   = '0;
        w_out   = 1'b0;
      end

      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
        w_out   = 1'b0;
      end
    endcase
  end

  assign ready = (r_state == S_IDLE);
  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_GAP);
  assign out   = r_out;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_pattern_tx
// Directed bench for serial_pattern_tx with default parameters. Expected
// per-cycle {out, done, busy, ready} vectors are built from the frame format
// and queued when stimulus is driven, then popped one per clock and compared
// against the DUT. Honours SERIAL_PATTERN_TX_PARITY_EN like the design.
// -----------------------------------------------------------------------------
module tb_serial_pattern_tx;

  localparam int DATA_W = 8;
  localparam int PRE_W  = 3;
  localparam logic [PRE_W-1:0] PRE_PAT = 3'b101;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam int FRAME_LEN = PRE_W + DATA_W + 2;
`else
  localparam int FRAME_LEN = PRE_W + DATA_W + 1;
`endif

  logic              clock;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              busy;
  logic              out;
  logic              done;

  // expected vector layout: {out, done, busy, ready}
  logic [3:0] exp_q[$];
  int         n_asserts;
  int         n_fail;
  int         cyc;

  serial_pattern_tx #(
    .DATA_W   (DATA_W),
    .PRE_W    (PRE_W),
    .PREAMBLE (PRE_PAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .data  (data),
    .ready (ready),
    .busy  (busy),
    .out   (out),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(4'b0001);
  endtask

  task automatic push_frame(input logic [DATA_W-1:0] d);
    for (int i = PRE_W - 1; i >= 0; i--) exp_q.push_back({PRE_PAT[i], 3'b010});
    for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back({d[i], 3'b010});
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    exp_q.push_back({^d, 3'b010});
`endif
    exp_q.push_back(4'b0110);
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge.
  task automatic run(input int n, input string tag);
    logic [3:0] e;
    logic [3:0] o;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      cyc++;
      o = {out, done, busy, ready};
      n_asserts++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL %s cycle %0d: observed %b with no expected entry", tag, cyc, o);
      end else begin
        e = exp_q.pop_front();
        assert (o === e) else begin
          n_fail++;
          $error("FAIL %s cycle %0d: {out,done,busy,ready} observed %b expected %b",
                 tag, cyc, o, e);
        end
      end
    end
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    cyc       = 0;
    reset     = 1'b1;
    start     = 1'b0;
    data      = '0;

    // Reset held 3 cycles, then idle
    push_idle(3);
    run(3, "reset");
    reset = 1'b0;
    push_idle(2);
    run(2, "post_reset_idle");

    // Single frame 8'hA5
    push_frame(8'hA5);
    push_idle(1);
    start = 1'b1;
    data  = 8'hA5;
    run(1, "a5_accept");
    start = 1'b0;
    data  = '0;
    run(FRAME_LEN, "a5_frame");

    // Frame 8'h07 then 8'hA5 (parity 1 then 0 when enabled)
    push_frame(8'h07);
    push_idle(1);
    start = 1'b1;
    data  = 8'h07;
    run(1, "07_accept");
    start = 1'b0;
    run(FRAME_LEN, "07_frame");
    push_frame(8'hA5);
    push_idle(1);
    start = 1'b1;
    data  = 8'hA5;
    run(1, "a5b_accept");
    start = 1'b0;
    run(FRAME_LEN, "a5b_frame");

    // start/data=FF pulsed during payload of an 8'h00 frame is ignored
    push_frame(8'h00);
    push_idle(3);
    start = 1'b1;
    data  = 8'h00;
    run(1, "00_accept");
    start = 1'b0;
    run(PRE_W + 2, "00_payload");
    start = 1'b1;
    data  = 8'hFF;
    run(1, "00_ignored_start");
    start = 1'b0;
    data  = 8'h00;
    run(FRAME_LEN + 3 - (PRE_W + 4), "00_rest");

    // start held high: back-to-back frames, data changes while busy
    push_frame(8'h3C);
    push_idle(1);
    push_frame(8'hC3);
    push_idle(1);
    start = 1'b1;
    data  = 8'h3C;
    run(1, "hold_accept1");
    data  = 8'hC3;
    run(FRAME_LEN, "hold_frame1");
    run(1, "hold_accept2");
    start = 1'b0;
    data  = 8'h55;
    run(FRAME_LEN, "hold_frame2");

    // Reset at payload bit 4, then a fresh frame
    push_frame(8'h5A);
    start = 1'b1;
    data  = 8'h5A;
    run(1, "rst_accept");
    start = 1'b0;
    run(PRE_W + 4, "rst_to_bit4");
    reset = 1'b1;
    exp_q.delete();
    push_idle(1);
    run(1, "mid_reset");
    reset = 1'b0;
    push_idle(1);
    run(1, "after_reset_idle");
    push_frame(8'h96);
    push_idle(1);
    start = 1'b1;
    data  = 8'h96;
    run(1, "fresh_accept");
    start = 1'b0;
    run(FRAME_LEN, "fresh_frame");

    n_asserts++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_drain: observed %0d leftover entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
